// File: rtl/buffer_scanout_pkg.sv
// buffer_scanout_pkg: default video timing and sync polarity shared by video blocks
package buffer_scanout_pkg;
  localparam int DEF_H_ACTIVE = 128;
  localparam int DEF_H_FP = 8;
  localparam int DEF_H_SYNC = 16;
  localparam int DEF_H_BP = 8;
  localparam int DEF_V_ACTIVE = 64;
  localparam int DEF_V_FP = 2;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 2;
  localparam logic SYNC_ACTIVE = 1'b0;
  function automatic logic sync_level(input logic on);
    return on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  endfunction
endpackage

// File: rtl/buffer_scanout_raster_timing.sv
// raster_timing: h/v raster counters with active, sync and vblank-start strobes
module raster_timing
  import buffer_scanout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic active,
  output logic hs,
  output logic vs,
  output logic first,
  output logic vblank_next,
  output logic frame_end
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic h_last, v_last;
  always_comb begin
    h_last = h_q == HW'(H_TOTAL - 1);
    v_last = v_q == VW'(V_TOTAL - 1);
    h_d = (!enable || h_last) ? '0 : h_q + 1'b1;
    v_d = !enable ? '0 : !h_last ? v_q : v_last ? '0 : v_q + 1'b1;
    active = enable && h_q < HW'(H_ACTIVE) && v_q < VW'(V_ACTIVE);
    hs = sync_level(enable && h_q >= HW'(H_ACTIVE + H_FP) && h_q < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs = sync_level(enable && v_q >= VW'(V_ACTIVE + V_FP) && v_q < VW'(V_ACTIVE + V_FP + V_SYNC));
    first = enable && h_q == '0 && v_q == '0;
    vblank_next = enable && h_last && v_q == VW'(V_ACTIVE - 1);
    frame_end = enable && h_last && v_last;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end
endmodule

// File: rtl/buffer_scanout.sv
// buffer_scanout: raster scan of the displayed frame buffer with vblank-aligned buffer swaps
module buffer_scanout
  import buffer_scanout_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  output logic [ADDRESS_WIDTH-1:0] buffer_address,
  input  logic [DATA_WIDTH-1:0]    buffer_data,
  input  logic                     swap_req,
  output logic                     swap_ack,
  output logic                     display_select,
  output logic [DATA_WIDTH-1:0]    pixel_data,
  output logic                     de,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     frame_start
);
  logic active0, hs0, vs0, first0, vblank_next, frame_end;
  logic [ADDRESS_WIDTH-1:0] a_q, a_d;
  logic act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;
  logic de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, frame_start_q, frame_start_d;
  logic [DATA_WIDTH-1:0] pixel_data_q, pixel_data_d;
  logic swap_ack_q, swap_ack_d, display_select_q, display_select_d;
  raster_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .active(active0),
    .hs(hs0),
    .vs(vs0),
    .first(first0),
    .vblank_next(vblank_next),
    .frame_end(frame_end)
  );
  // Swap is decided on the edge that enters vblank, so the new buffer is never visible mid-frame.
  always_comb begin
    a_d = (!enable || frame_end) ? '0 : active0 ? a_q + 1'b1 : a_q;
    act1_d = active0;
    hs1_d = hs0;
    vs1_d = vs0;
    fs1_d = first0;
    de_d = act1_q;
    hsync_d = hs1_q;
    vsync_d = vs1_q;
    frame_start_d = fs1_q;
    pixel_data_d = act1_q ? buffer_data : '0;
    swap_ack_d = vblank_next && swap_req;
    display_select_d = display_select_q ^ swap_ack_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      act1_q <= 1'b0;
      hs1_q <= ~SYNC_ACTIVE;
      vs1_q <= ~SYNC_ACTIVE;
      fs1_q <= 1'b0;
      de_q <= 1'b0;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      frame_start_q <= 1'b0;
      pixel_data_q <= '0;
      swap_ack_q <= 1'b0;
      display_select_q <= 1'b0;
    end else begin
      a_q <= a_d;
      act1_q <= act1_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      fs1_q <= fs1_d;
      de_q <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      frame_start_q <= frame_start_d;
      pixel_data_q <= pixel_data_d;
      swap_ack_q <= swap_ack_d;
      display_select_q <= display_select_d;
    end
  end
  assign buffer_address = active0 ? a_q : '0;
  assign swap_ack = swap_ack_q;
  assign display_select = display_select_q;
  assign pixel_data = pixel_data_q;
  assign de = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_buffer_scanout.sv
// tb_buffer_scanout: randomized scanout checks against a raster-position reference model
module tb_buffer_scanout;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1, VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FT = HT * VT;
  localparam logic [19:0] IDLE = {1'b0, 1'b1, 1'b1, 1'b0, 16'h0};
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, swap_req = 1'b0;
  logic [15:0] buffer_address, buffer_data, pixel_data;
  logic swap_ack, display_select, de, hsync, vsync, frame_start;
  logic [15:0] mem [2][16];
  int checks = 0, passed = 0, cnt = 0, e1 = -1, e2 = -1;
  logic sel_exp = 1'b0, ack_exp = 1'b0;
  logic [19:0] vid;
  logic [1:0] ctl;
  assign vid = {de, hsync, vsync, frame_start, pixel_data};
  assign ctl = {display_select, swap_ack};
  always #5 clk = ~clk;
  always @(posedge clk) buffer_data <= mem[display_select][buffer_address[3:0]];
  buffer_scanout #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(16),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .buffer_address(buffer_address), .buffer_data(buffer_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .display_select(display_select),
    .pixel_data(pixel_data), .de(de), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start)
  );
  // Video outputs expected for a raster position e taken two clocks earlier (-1 = idle).
  function automatic logic [19:0] exp_vid(int e);
    int h, l;
    logic d;
    if (e < 0) return IDLE;
    h = e % HT;
    l = e / HT;
    d = h < HA && l < VA;
    return {d, !(h >= HA + HF && h < HA + HF + HS), !(l >= VA + VF && l < VA + VF + VS),
            e == 0, d ? mem[sel_exp][l * HA + h] : 16'h0};
  endfunction
  function automatic logic [15:0] exp_addr(int e);
    int h, l;
    if (e < 0) return 16'h0;
    h = e % HT;
    l = e / HT;
    return (h < HA && l < VA) ? 16'(l * HA + h) : 16'h0;
  endfunction
  task automatic tick();
    int e0 = enable ? cnt : -1;
    int nxt = enable ? (cnt + 1) % FT : 0;
    logic sw = enable && nxt == VA * HT && swap_req;
    @(posedge clk);
    cnt = nxt;
    e2 = e1;
    e1 = e0;
    sel_exp ^= sw;
    ack_exp = sw;
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (vid !== IDLE) $display("FAIL reset_video got %h exp %h", vid, IDLE); else passed++;
    checks++; if (ctl !== 2'b00) $display("FAIL reset_ctl got %b exp 00", ctl); else passed++;
    checks++; if (buffer_address !== 16'h0) $display("FAIL reset_addr got %h exp 0", buffer_address); else passed++;
    rst_n = 1'b1;
  endtask
  task automatic test_scan();
    int de_n = 0, vs_n = 0, hs_n = 0, fs_n = 0;
    for (int i = 0; i < 2 * FT + 2; i++) begin
      checks++; if (buffer_address !== exp_addr(cnt)) $display("FAIL scan_addr i=%0d got %h exp %h", i, buffer_address, exp_addr(cnt)); else passed++;
      checks++; if (vid !== exp_vid(e2)) $display("FAIL scan_video i=%0d got %h exp %h", i, vid, exp_vid(e2)); else passed++;
      if (i >= 2) begin
        de_n += int'(de);
        vs_n += int'(!vsync);
        hs_n += int'(!hsync);
        fs_n += int'(frame_start);
      end
      tick();
    end
    checks++; if (de_n != 2 * HA * VA) $display("FAIL scan_de_count got %0d exp %0d", de_n, 2 * HA * VA); else passed++;
    checks++; if (vs_n != 2 * HT * VS) $display("FAIL scan_vsync_count got %0d exp %0d", vs_n, 2 * HT * VS); else passed++;
    checks++; if (hs_n != 2 * VT * HS) $display("FAIL scan_hsync_count got %0d exp %0d", hs_n, 2 * VT * HS); else passed++;
    checks++; if (fs_n != 2) $display("FAIL scan_frame_start_count got %0d exp 2", fs_n); else passed++;
  endtask
  task automatic test_swap();
    int target = int'($urandom_range(0, VA * HT - 1));
    int hold = int'($urandom_range(0, 2 * HT));
    int acks = 0;
    logic seen = 1'b0;
    for (int i = 0; i < FT && cnt != target; i++) tick();
    swap_req = 1'b1;
    for (int i = 0; i < 2 * FT && !seen; i++) begin
      tick();
      checks++; if (ctl !== {sel_exp, ack_exp}) $display("FAIL swap_ctl i=%0d got %b exp %b", i, ctl, {sel_exp, ack_exp}); else passed++;
      checks++; if (vid !== exp_vid(e2)) $display("FAIL swap_video i=%0d got %h exp %h", i, vid, exp_vid(e2)); else passed++;
      seen = swap_ack;
    end
    checks++; if (seen !== 1'b1) $display("FAIL swap_ack_timeout got %b exp 1", seen); else passed++;
    repeat (hold) tick();
    swap_req = 1'b0;
    for (int i = 0; i < FT + HT; i++) begin
      tick();
      checks++; if (ctl !== {sel_exp, ack_exp}) $display("FAIL swap_idle_ctl i=%0d got %b exp %b", i, ctl, {sel_exp, ack_exp}); else passed++;
      checks++; if (vid !== exp_vid(e2)) $display("FAIL swap_idle_video i=%0d got %h exp %h", i, vid, exp_vid(e2)); else passed++;
      acks += int'(swap_ack);
    end
    checks++; if (acks != 0) $display("FAIL swap_no_repeat got %0d acks exp 0", acks); else passed++;
    checks++; if (display_select !== 1'b1) $display("FAIL swap_select got %b exp 1", display_select); else passed++;
  endtask
  task automatic test_back_to_back();
    int acks = 0, first = -1, last = -1;
    swap_req = 1'b1;
    for (int i = 0; i < 2 * FT; i++) begin
      tick();
      checks++; if (ctl !== {sel_exp, ack_exp}) $display("FAIL b2b_ctl i=%0d got %b exp %b", i, ctl, {sel_exp, ack_exp}); else passed++;
      if (swap_ack) begin
        acks++;
        if (first < 0) first = i;
        last = i;
      end
    end
    swap_req = 1'b0;
    checks++; if (acks != 2) $display("FAIL b2b_ack_count got %0d exp 2", acks); else passed++;
    checks++; if (last - first != FT) $display("FAIL b2b_ack_spacing got %0d exp %0d", last - first, FT); else passed++;
    checks++; if (display_select !== 1'b1) $display("FAIL b2b_select got %b exp 1", display_select); else passed++;
  endtask
  task automatic test_disable();
    for (int i = 0; i < 2 * FT && cnt != HT + 2; i++) tick();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (vid !== exp_vid(e2)) $display("FAIL dis_video i=%0d got %h exp %h", i, vid, exp_vid(e2)); else passed++;
      checks++; if (buffer_address !== 16'h0) $display("FAIL dis_addr i=%0d got %h exp 0", i, buffer_address); else passed++;
      if (i == 1) begin
        checks++; if (vid !== IDLE) $display("FAIL dis_idle_2clk got %h exp %h", vid, IDLE); else passed++;
      end
    end
    checks++; if (ctl !== {sel_exp, 1'b0}) $display("FAIL dis_ctl got %b exp %b", ctl, {sel_exp, 1'b0}); else passed++;
    enable = 1'b1;
    #1;
    checks++; if (buffer_address !== 16'h0) $display("FAIL reen_addr0 got %h exp 0", buffer_address); else passed++;
    for (int i = 0; i < FT; i++) begin
      tick();
      checks++; if (buffer_address !== exp_addr(cnt)) $display("FAIL reen_addr i=%0d got %h exp %h", i, buffer_address, exp_addr(cnt)); else passed++;
      checks++; if (vid !== exp_vid(e2)) $display("FAIL reen_video i=%0d got %h exp %h", i, vid, exp_vid(e2)); else passed++;
      if (i == 1) begin
        checks++; if (frame_start !== 1'b1) $display("FAIL reen_frame_start got %b exp 1", frame_start); else passed++;
      end
    end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < FT && cnt != HT + 1; i++) tick();
    checks++; if (display_select !== 1'b1) $display("FAIL ares_pre_select got %b exp 1", display_select); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (vid !== IDLE) $display("FAIL ares_video got %h exp %h", vid, IDLE); else passed++;
    checks++; if (ctl !== 2'b00) $display("FAIL ares_ctl got %b exp 00", ctl); else passed++;
    checks++; if (buffer_address !== 16'h0) $display("FAIL ares_addr got %h exp 0", buffer_address); else passed++;
    cnt = 0; e1 = -1; e2 = -1; sel_exp = 1'b0; ack_exp = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[0][i] = 16'h1000 + 16'(i);
      mem[1][i] = 16'($urandom);
    end
    test_reset();
    test_scan();
    test_swap();
    test_back_to_back();
    test_disable();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
